// File: rtl/cpu.sv
// cpu: single-cycle 16-bit CPU with ROM image PROGRAM and 2**AW-word data RAM; ports clk, rst_n (sync active-low), hlt (current inst is HLT), pc (current byte address)
module cpu #(
  parameter int AW = 8,
  parameter logic [15:0] PROGRAM [2**AW] = '{default: 16'hF000}
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        hlt,
  output logic [15:0] pc
);
  typedef enum logic [3:0] {
    ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT
  } op_t;
  op_t op;
  logic [15:0] rf [16];
  logic [15:0] dmem [2**AW];
  logic [15:0] data_out, addr, data_in, mem_data, dst_data, a, b, red, padd, sat, pc_inc, pc_next;
  logic [16:0] sum;
  logic [7:0] conds;
  logic [3:0] dst_reg, rs_id, rt_id, imm4;
  logic reg_write, mem_read, mem_write, z, n, v, ovf, taken, set_z, set_all, unused_ok;
  assign data_out = PROGRAM[pc[AW:1]];
  assign op = op_t'(data_out[15:12]);
  assign dst_reg = data_out[11:8];
  assign rs_id = data_out[7:4];
  assign imm4 = data_out[3:0];
  assign rt_id = (op == SW || op == LLB || op == LHB) ? dst_reg : data_out[3:0];
  assign a = rs_id == 4'd0 ? 16'd0 : rf[rs_id];
  assign b = rt_id == 4'd0 ? 16'd0 : rf[rt_id];
  assign addr = (a & 16'hFFFE) + {{11{imm4[3]}}, imm4, 1'b0};
  assign data_in = b;
  assign mem_read = op == LW;
  assign mem_write = op == SW;
  assign mem_data = dmem[addr[AW:1]];
  assign sum = op == SUB ? {a[15], a} - {b[15], b} : {a[15], a} + {b[15], b};
  assign ovf = sum[16] ^ sum[15];
  assign sat = ovf ? {sum[16], {15{~sum[16]}}} : sum[15:0];
  assign red = {{8{a[15]}}, a[15:8]} + {{8{a[7]}}, a[7:0]} + {{8{b[15]}}, b[15:8]} + {{8{b[7]}}, b[7:0]};
  for (genvar g = 0; g < 4; g++) begin : g_nib
    logic [4:0] s;
    assign s = {a[4*g+3], a[4*g+:4]} + {b[4*g+3], b[4*g+:4]};
    assign padd[4*g+:4] = s[4] ^ s[3] ? {s[4], {3{~s[4]}}} : s[3:0];
  end
  always_comb begin
    dst_data = sat;
    case (op)
      XOR:     dst_data = a ^ b;
      RED:     dst_data = red;
      SLL:     dst_data = a << imm4;
      SRA:     dst_data = $signed(a) >>> imm4;
      ROR:     dst_data = (a >> imm4) | (a << (5'd16 - {1'b0, imm4}));
      PADDSB:  dst_data = padd;
      LW:      dst_data = mem_data;
      LLB:     dst_data = {b[15:8], data_out[7:0]};
      LHB:     dst_data = {data_out[7:0], b[7:0]};
      PCS:     dst_data = pc_inc;
      default: dst_data = sat;
    endcase
  end
  assign reg_write = !(op inside {SW, B, BR, HLT});
  assign hlt = op == HLT;
  assign set_all = op == ADD || op == SUB;
  assign set_z = set_all || op inside {XOR, SLL, SRA, ROR};
  // condition table indexed by cond field: 111 always, 110 V, 101 N|Z, 100 Z|GT, 011 N, 010 GT, 001 Z, 000 !Z
  assign conds = {1'b1, v, n | z, z | (!z && !n), n, !z && !n, z, !z};
  assign taken = conds[data_out[11:9]];
  assign pc_inc = pc + 16'd2;
  assign pc_next = hlt ? pc
                 : (op == B && taken) ? pc_inc + {{6{data_out[8]}}, data_out[8:0], 1'b0}
                 : (op == BR && taken) ? a
                 : pc_inc;
  assign unused_ok = ^{pc[15:AW+1], pc[0], addr[15:AW+1], addr[0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      z <= 1'b0;
      n <= 1'b0;
      v <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (reg_write && dst_reg != 4'd0) rf[dst_reg] <= dst_data;
      if (set_z) z <= dst_data == 16'd0;
      if (set_all) begin
        n <= dst_data[15];
        v <= ovf;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst_n && mem_write) dmem[addr[AW:1]] <= data_in;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program run for cpu with a per-cycle expected-trace scoreboard
module tb_cpu;
  logic clk = 1'b0;
  logic rst_n;
  logic hlt;
  logic [15:0] pc;
  localparam logic [15:0] PROG [256] = '{
    0: 16'hA6FF, 1: 16'hB67F, 2: 16'h0766, 3: 16'hCC1C, 4: 16'hF000,
    5: 16'hA134, 6: 16'hB112, 7: 16'h1411, 8: 16'hC202, 9: 16'hF000,
    10: 16'hF000, 11: 16'hC1F0, 12: 16'h0211, 13: 16'h9101, 14: 16'h8301,
    15: 16'h2812, 16: 16'hE500, 17: 16'hCC06, 18: 16'h0066, 19: 16'hDE50,
    32: 16'h3A67, 33: 16'h7B67, 34: 16'h4C64, 35: 16'h5DC8, 36: 16'h6E64,
    37: 16'h1FC6, 38: 16'hCFDE,
    default: 16'hF000
  };
  cpu #(.AW(8), .PROGRAM(PROG)) dut (.clk(clk), .rst_n(rst_n), .hlt(hlt), .pc(pc));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] pc;
    logic [2:0]  f;
    logic [3:0]  ctl;
    logic [3:0]  rd;
    logic [15:0] wd;
    logic [15:0] ma;
    logic [15:0] md;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  // f = {z,n,v} before the instruction executes; ctl = {hlt, reg_write, mem_read, mem_write}
  task automatic exp(input logic [15:0] p, input logic [2:0] f, input logic [3:0] ctl,
                     input logic [3:0] rd, input logic [15:0] wd, input logic [15:0] ma, input logic [15:0] md);
    sb.push_back('{p, f, ctl, rd, wd, ma, md});
  endtask
  task automatic drain;
    exp_t e;
    string t;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = $sformatf("@%h", e.pc);
      chk({"pc", t}, pc, e.pc);
      chk({"flags", t}, {13'd0, dut.z, dut.n, dut.v}, 16'(e.f));
      chk({"hlt", t}, 16'(hlt), 16'(e.ctl[3]));
      chk({"reg_write", t}, 16'(dut.reg_write), 16'(e.ctl[2]));
      if (e.ctl[2]) begin
        chk({"dst_reg", t}, 16'(dut.dst_reg), 16'(e.rd));
        chk({"dst_data", t}, dut.dst_data, e.wd);
      end
      chk({"mem_read", t}, 16'(dut.mem_read), 16'(e.ctl[1]));
      chk({"mem_write", t}, 16'(dut.mem_write), 16'(e.ctl[0]));
      if (e.ctl[1] || e.ctl[0]) chk({"addr", t}, dut.addr, e.ma);
      if (e.ctl[0]) chk({"data_in", t}, dut.data_in, e.md);
      @(negedge clk);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", pc, 16'h0000);
    chk("reset hlt", 16'(hlt), 16'h0000);
    chk("reset flags", {13'd0, dut.z, dut.n, dut.v}, 16'h0000);
    chk("reset r6", dut.rf[6], 16'h0000);
    rst_n = 1'b1;
    exp(16'h0000, 3'b000, 4'b0100, 4'h6, 16'h00FF, 16'h0, 16'h0);
    exp(16'h0002, 3'b000, 4'b0100, 4'h6, 16'h7FFF, 16'h0, 16'h0);
    exp(16'h0004, 3'b000, 4'b0100, 4'h7, 16'h7FFF, 16'h0, 16'h0);
    exp(16'h0006, 3'b001, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h0040, 3'b001, 4'b0100, 4'hA, 16'h00FC, 16'h0, 16'h0);
    exp(16'h0042, 3'b001, 4'b0100, 4'hB, 16'h7EEE, 16'h0, 16'h0);
    exp(16'h0044, 3'b001, 4'b0100, 4'hC, 16'hFFF0, 16'h0, 16'h0);
    exp(16'h0046, 3'b001, 4'b0100, 4'hD, 16'hFFFF, 16'h0, 16'h0);
    exp(16'h0048, 3'b001, 4'b0100, 4'hE, 16'hF7FF, 16'h0, 16'h0);
    exp(16'h004A, 3'b001, 4'b0100, 4'hF, 16'h8000, 16'h0, 16'h0);
    exp(16'h004C, 3'b011, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h000A, 3'b011, 4'b0100, 4'h1, 16'h0034, 16'h0, 16'h0);
    exp(16'h000C, 3'b011, 4'b0100, 4'h1, 16'h1234, 16'h0, 16'h0);
    exp(16'h000E, 3'b011, 4'b0100, 4'h4, 16'h0000, 16'h0, 16'h0);
    exp(16'h0010, 3'b100, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h0016, 3'b100, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h0018, 3'b100, 4'b0100, 4'h2, 16'h2468, 16'h0, 16'h0);
    exp(16'h001A, 3'b000, 4'b0001, 4'h0, 16'h0000, 16'h0002, 16'h1234);
    exp(16'h001C, 3'b000, 4'b0110, 4'h3, 16'h1234, 16'h0002, 16'h0);
    exp(16'h001E, 3'b000, 4'b0100, 4'h8, 16'h365C, 16'h0, 16'h0);
    exp(16'h0020, 3'b000, 4'b0100, 4'h5, 16'h0022, 16'h0, 16'h0);
    exp(16'h0022, 3'b000, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h0024, 3'b000, 4'b0100, 4'h0, 16'h7FFF, 16'h0, 16'h0);
    exp(16'h0026, 3'b001, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    exp(16'h0022, 3'b001, 4'b0000, 4'h0, 16'h0000, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) exp(16'h0030, 3'b001, 4'b1000, 4'h0, 16'h0000, 16'h0, 16'h0);
    drain();
    chk("r0 stays zero", dut.rf[0], 16'h0000);
    chk("r5 pcs", dut.rf[5], 16'h0022);
    chk("r3 lw", dut.rf[3], 16'h1234);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rerun pc", pc, 16'h0000);
    chk("rerun hlt", 16'(hlt), 16'h0000);
    chk("rerun flags", {13'd0, dut.z, dut.n, dut.v}, 16'h0000);
    chk("rerun r6 cleared", dut.rf[6], 16'h0000);
    chk("dmem kept", dut.dmem[1], 16'h1234);
    rst_n = 1'b1;
    exp(16'h0000, 3'b000, 4'b0100, 4'h6, 16'h00FF, 16'h0, 16'h0);
    exp(16'h0002, 3'b000, 4'b0100, 4'h6, 16'h7FFF, 16'h0, 16'h0);
    drain();
    chk("rerun r6", dut.rf[6], 16'h7FFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port hlt, output, 1 bit: high while the current instruction is HLT.
REQ-004 SHALL have port pc, output, 16 bits: byte address of the current instruction.
REQ-005 SHALL contain internal observables: RegWrite, MemRead, MemWrite, register-file DstReg[3:0]/DstData[15:0], data-memory addr[15:0]/data_in[15:0], instruction-memory data_out[15:0].

Function
REQ-006 SHALL be single-cycle: fetch, decode, execute, memory and writeback complete in one clk; one instruction retires per cycle.
REQ-007 SHALL use separate instruction and data memories, 16-bit words, byte-addressed with addr[0] ignored; instruction memory preloaded at time 0 from instructions.img (hex); memory reads combinational, writes on clk edge.
REQ-008 SHALL have 16 x 16-bit registers, 2 read ports combinational, 1 write port on clk; R0 reads 0, writes to R0 discarded.
REQ-009 SHALL decode opcode=inst[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm4=[3:0], imm8=[7:0].
REQ-010 SHALL implement 0000 ADD, 0001 SUB: rd=rs±rt, 16-bit signed saturating (clamp 0x7FFF/0x8000); set Z, N from result, V=1 on saturation.
REQ-011 SHALL implement 0010 XOR: rd=rs^rt; update Z only.
REQ-012 SHALL implement 0011 RED: rd = sign-extended sum of the four signed bytes of rs and rt; flags unchanged.
REQ-013 SHALL implement 0100 SLL, 0101 SRA (arithmetic), 0110 ROR (rotate right): rd = rs shifted by imm4 (0..15); update Z only.
REQ-014 SHALL implement 0111 PADDSB: four independent 4-bit signed saturating adds (clamp +7/-8); flags unchanged.
REQ-015 SHALL implement 1000 LW: rd = Mem[(rs & 0xFFFE) + (sext(imm4)<<1)]; MemRead=1.
REQ-016 SHALL implement 1001 SW: Mem[same address] = register [11:8]; MemWrite=1, RegWrite=0.
REQ-017 SHALL implement 1010 LLB: rd = (rd & 0xFF00)|imm8; 1011 LHB: rd = (rd & 0x00FF)|(imm8<<8).
REQ-018 SHALL implement 1100 B: cond=[11:9], imm9=[8:0]; taken -> PC = PC+2+(sext(imm9)<<1), else PC+2.
REQ-019 SHALL implement 1101 BR: cond=[11:9]; taken -> PC = rs, else PC+2.
REQ-020 SHALL implement 1110 PCS: rd = PC+2.
REQ-021 SHALL implement 1111 HLT: hlt=1 combinationally, PC holds, no register/memory write.
REQ-022 SHALL evaluate cond: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-023 SHALL update flags Z,V,N only on clk edge of the executing instruction; flags read by a branch are those from prior instructions.
REQ-024 SHALL, for all non-control instructions, advance PC by 2 with 16-bit wrap (0xFFFE -> 0x0000).
REQ-025 SHALL drive RegWrite=1 for ADD,SUB,XOR,RED,SLL,SRA,ROR,PADDSB,LW,LLB,LHB,PCS; 0 otherwise.

Reset
REQ-026 SHALL, on clk edge with rst_n=0, set PC=0x0000, all registers=0, Z=V=N=0; hlt follows instruction at 0x0000 after release.
REQ-027 SHALL suppress register and data-memory writes while rst_n=0; instruction/data memory contents not cleared.
REQ-028 SHALL restart from PC=0 on reset asserted mid-program, including after HLT.

Verification
REQ-029 LLB R1,0x34; LHB R1,0x12; ADD R2,R1,R1 -> R1=0x1234, R2=0x2468, Z=N=V=0.
REQ-030 LLB R1,0xFF; LHB R1,0x7F; ADD R2,R1,R1 -> R2=0x7FFF saturated, V=1; B cond=110 taken.
REQ-031 SW R1,[R0+2] with R1=0x1234; LW R3,[R0+2] -> addr 0x0002, R3=0x1234, MemRead=1 on LW.
REQ-032 SUB R4,R1,R1 -> R4=0, Z=1; B EQ offset +2 at PC 0x0010 -> next PC 0x0016; B NE not taken -> PC+2.
REQ-033 PCS R5 at PC 0x0020 -> R5=0x0022; BR 111 R5 -> PC=0x0022; ADD R0,R1,R1 -> R0 remains 0.
REQ-034 HLT at PC 0x0030 -> hlt=1, pc stays 0x0030 for all later cycles; rst_n=0 for 2 cycles -> pc=0x0000, hlt reflects inst at 0.
